hazard_dest_tracker: RTL and testbench
======================================

HAZARD_DEST_TRACKER -- requirements
Module: hazard_dest_tracker

Interface
REQ-001 SHALL have parameter: STALL_TIMEOUT, 15, consecutive stalled cycles (1..255) that flag a stuck pipeline.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: ID_valid_ip  input  1  ID stage holds a real instruction.
REQ-005 SHALL have port: ID_instr_opcode_ip  input  7  opcode of the ID instruction.
REQ-006 SHALL have port: ID_reg_dest_ip  input  5  rd field of the ID instruction.
REQ-007 SHALL have port: stall_ip  input  1  stall request from the stall controller.
REQ-008 SHALL have port: flush_ip  input  1  control redirect; kill the ID instruction.
REQ-009 SHALL have port: EX_instr_opcode_op  output  7  opcode in the EX slot.
REQ-010 SHALL have port: EX_reg_dest_op  output  5  destination register in the EX slot.
REQ-011 SHALL have port: LSU_reg_dest_op  output  5  destination register in the LSU slot.
REQ-012 SHALL have port: WB_reg_dest_op  output  5  destination register in the WB slot.
REQ-013 SHALL have port: WB_write_reg_en_op  output  1  WB slot writes the register file.
REQ-014 SHALL have port: IF_ID_hold_op  output  1  freeze PC and the IF/ID register this cycle.
REQ-015 SHALL have port: stall_count_op  output  16  total stalled cycles since reset.
REQ-016 SHALL have port: stall_timeout_op  output  1  sticky stuck-pipeline flag.

Function
REQ-017 SHALL hold three registered slots, EX, LSU and WB; each slot holds {opcode, dest, wen}.
REQ-018 SHALL define a bubble as opcode 7'b0, dest 0 and wen 0.
REQ-019 SHALL compute "accept" as ID_valid_ip && !stall_ip && !flush_ip.
REQ-020 SHALL update the slots on every clock edge:
  - WB<=LSU
  - LSU<=EX
  - EX<=accept ? ID fields : bubble
  - The slots shall never freeze.
REQ-021 SHALL set wen=1 only for opcodes OP, OPIMM, LOAD, LUI, AUIPC, JAL and JALR, and only if the dest is nonzero. STORE, BRANCH, SYSTEM and unknown opcodes shall get wen=0.
REQ-022 SHALL store dest=0 whenever wen=0, so a non-writing instruction never aliases a hazard.
REQ-023 SHALL drive IF_ID_hold_op combinationally as stall_ip && ID_valid_ip && !flush_ip; flush overrides stall.
REQ-024 SHALL increment stall_count_op by one on each edge where IF_ID_hold_op=1, saturating at 16'hFFFF.
REQ-025 SHALL keep an 8-bit run counter: it increments on each edge with IF_ID_hold_op=1 and clears on any edge with IF_ID_hold_op=0.
REQ-026 SHALL set stall_timeout_op on the edge where the run counter reaches STALL_TIMEOUT. The flag shall stay set until reset; the run counter shall saturate there.
REQ-027 SHALL let ID_valid_ip=0 load a bubble into EX regardless of stall_ip and flush_ip.

Reset
REQ-028 SHALL, on reset low, asynchronously load all three slots with bubbles.
REQ-029 SHALL, on reset low, clear stall_count_op, the run counter and stall_timeout_op. All registered outputs then read 0; IF_ID_hold_op follows its inputs.
REQ-030 SHALL restart slot advance on the first rising clk edge after reset deasserts, with no extra latency cycle.

Structure
REQ-031 SHALL place the opcode constants (OPCODE_LOAD, OPCODE_STORE, OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH) in CORE_PKG, alongside the existing opcode constants.
REQ-032 SHALL place typedef pipe_slot_t and constant BUBBLE_SLOT in CORE_PKG.
REQ-033 SHALL contain exactly one sub-module, stall_watchdog, holding the run counter, stall_count_op and stall_timeout_op.
REQ-034 SHALL be connectable with its EX, LSU and WB outputs wired directly to the matching stall-controller inputs.

Verification
REQ-035 SHALL cover writing instruction flow: ADD with rd=x5 and valid=1 for one cycle -> EX_reg_dest_op=5 at edge 1, LSU=5 at edge 2, WB=5 with wen=1 at edge 3, all 0 at edge 4.
REQ-036 SHALL cover non-writing instructions: STORE with rd field 5 -> WB_reg_dest_op=0 and wen=0. ADD with rd=x0 -> wen=0 throughout.
REQ-037 SHALL cover a two-cycle stall: stall_ip=1 with valid=1 for 2 cycles -> IF_ID_hold_op=1 both cycles, two bubbles enter EX, stall_count_op=2, instruction enters EX on edge 3.
REQ-038 SHALL cover simultaneous stall and flush: stall_ip=1, flush_ip=1, valid=1 -> IF_ID_hold_op=0, bubble enters EX, stall_count_op unchanged.
REQ-039 SHALL cover watchdog timeout: stall_ip held 15 cycles -> stall_timeout_op=1 after edge 15 and stays 1 after stall_ip drops. A 14-cycle stall followed by a release -> flag stays 0.
REQ-040 SHALL cover reset mid-operation: reset low with LOAD x7 in LSU -> all slots, counters and flag read 0 immediately with no clock edge. First instruction after release reaches EX at edge 1.

Source files
------------

// File: rtl/core_pkg.sv
// Core-wide opcode constants and pipeline slot types shared by the
// hazard tracking and stall control logic.
package core_pkg;

  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] dest;
    logic       wen;
  } pipe_slot_t;

  localparam pipe_slot_t BUBBLE_SLOT = '{opcode: 7'b0, dest: 5'd0, wen: 1'b0};

  // Opcode classes that produce a register result.
  function automatic logic opcode_writes_rd(input logic [6:0] opcode);
    case (opcode)
      OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD, OPCODE_LUI,
      OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR: opcode_writes_rd = 1'b1;
      default:                               opcode_writes_rd = 1'b0;
    endcase
  endfunction

  // Build a slot from raw ID fields; x0 and non-writers carry dest 0.
  function automatic pipe_slot_t make_slot(input logic [6:0] opcode,
                                           input logic [4:0] dest);
    pipe_slot_t s;
    s.opcode = opcode;
    s.wen    = opcode_writes_rd(opcode) && (dest != 5'd0);
    s.dest   = s.wen ? dest : 5'd0;
    return s;
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts stalled cycles (saturating) and raises a sticky flag when a single
// stall run lasts STALL_TIMEOUT cycles.
module stall_watchdog #(
  parameter int STALL_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  output logic [15:0] stall_count,
  output logic        stall_timeout
);

  localparam logic [7:0] RUN_LIMIT = STALL_TIMEOUT[7:0];

  logic [7:0] run_q;
  logic [7:0] run_nxt;

  // Run counter parks at the limit so it cannot wrap back under it.
  always_comb begin
    run_nxt = 8'd0;
    if (hold) run_nxt = (run_q == RUN_LIMIT) ? run_q : run_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q         <= 8'd0;
      stall_count   <= 16'd0;
      stall_timeout <= 1'b0;
    end else begin
      run_q <= run_nxt;
      if (hold && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
      if (hold && run_nxt == RUN_LIMIT) stall_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_dest_tracker.sv
// Tracks opcode/destination/write-enable of the EX, LSU and WB slots so the
// stall controller can detect RAW hazards; slots always advance.
module hazard_dest_tracker
  import core_pkg::*;
#(
  parameter int STALL_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_valid_ip,
  input  logic [6:0]  ID_instr_opcode_ip,
  input  logic [4:0]  ID_reg_dest_ip,
  input  logic        stall_ip,
  input  logic        flush_ip,
  output logic [6:0]  EX_instr_opcode_op,
  output logic [4:0]  EX_reg_dest_op,
  output logic [4:0]  LSU_reg_dest_op,
  output logic [4:0]  WB_reg_dest_op,
  output logic        WB_write_reg_en_op,
  output logic        IF_ID_hold_op,
  output logic [15:0] stall_count_op,
  output logic        stall_timeout_op
);

  pipe_slot_t ex_q, lsu_q, wb_q;
  pipe_slot_t id_slot;
  logic       accept;

  assign accept  = ID_valid_ip && !stall_ip && !flush_ip;
  assign id_slot = make_slot(ID_instr_opcode_ip, ID_reg_dest_ip);

  // Flush wins over stall: a killed instruction must not freeze fetch.
  assign IF_ID_hold_op = stall_ip && ID_valid_ip && !flush_ip;

  // No enable on purpose: a stalled ID feeds bubbles while older work drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= BUBBLE_SLOT;
      lsu_q <= BUBBLE_SLOT;
      wb_q  <= BUBBLE_SLOT;
    end else begin
      ex_q  <= accept ? id_slot : BUBBLE_SLOT;
      lsu_q <= ex_q;
      wb_q  <= lsu_q;
    end
  end

  assign EX_instr_opcode_op = ex_q.opcode;
  assign EX_reg_dest_op     = ex_q.dest;
  assign LSU_reg_dest_op    = lsu_q.dest;
  assign WB_reg_dest_op     = wb_q.dest;
  assign WB_write_reg_en_op = wb_q.wen;

  logic unused_wb_opcode;
  assign unused_wb_opcode = ^wb_q.opcode;

  stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT)
  ) u_stall_watchdog (
    .clk           (clk),
    .reset         (reset),
    .hold          (IF_ID_hold_op),
    .stall_count   (stall_count_op),
    .stall_timeout (stall_timeout_op)
  );

endmodule

// File: tb/tb_hazard_dest_tracker.sv
// Directed bench for hazard_dest_tracker: slot flow, write-enable masking,
// stall/flush hold, watchdog timeout and asynchronous reset.
module tb_hazard_dest_tracker;

  logic        clk;
  logic        reset;
  logic        ID_valid_ip;
  logic [6:0]  ID_instr_opcode_ip;
  logic [4:0]  ID_reg_dest_ip;
  logic        stall_ip;
  logic        flush_ip;
  logic [6:0]  EX_instr_opcode_op;
  logic [4:0]  EX_reg_dest_op;
  logic [4:0]  LSU_reg_dest_op;
  logic [4:0]  WB_reg_dest_op;
  logic        WB_write_reg_en_op;
  logic        IF_ID_hold_op;
  logic [15:0] stall_count_op;
  logic        stall_timeout_op;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  hazard_dest_tracker #(.STALL_TIMEOUT(15)) dut (
    .clk                (clk),
    .reset              (reset),
    .ID_valid_ip        (ID_valid_ip),
    .ID_instr_opcode_ip (ID_instr_opcode_ip),
    .ID_reg_dest_ip     (ID_reg_dest_ip),
    .stall_ip           (stall_ip),
    .flush_ip           (flush_ip),
    .EX_instr_opcode_op (EX_instr_opcode_op),
    .EX_reg_dest_op     (EX_reg_dest_op),
    .LSU_reg_dest_op    (LSU_reg_dest_op),
    .WB_reg_dest_op     (WB_reg_dest_op),
    .WB_write_reg_en_op (WB_write_reg_en_op),
    .IF_ID_hold_op      (IF_ID_hold_op),
    .stall_count_op     (stall_count_op),
    .stall_timeout_op   (stall_timeout_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns past it.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                       input logic st, input logic fl);
    ID_valid_ip        = v;
    ID_instr_opcode_ip = op;
    ID_reg_dest_ip     = rd;
    stall_ip           = st;
    flush_ip           = fl;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 7'd0, 5'd0, 1'b0, 1'b0);
    #12;
    chk("rst_ex_dest", {27'd0, EX_reg_dest_op}, 32'd0);
    chk("rst_wb_wen", {31'd0, WB_write_reg_en_op}, 32'd0);
    chk("rst_count", {16'd0, stall_count_op}, 32'd0);
    chk("rst_flag", {31'd0, stall_timeout_op}, 32'd0);
    reset = 1'b1;
    edge1();

    // ADD x5 flows EX -> LSU -> WB then drains.
    drive(1'b1, OP_ADD, 5'd5, 1'b0, 1'b0);
    chk("add_hold", {31'd0, IF_ID_hold_op}, 32'd0);
    edge1();
    chk("add_ex_dest", {27'd0, EX_reg_dest_op}, 32'd5);
    chk("add_ex_op", {25'd0, EX_instr_opcode_op}, {25'd0, OP_ADD});
    drive(1'b0, 7'd0, 5'd0, 1'b0, 1'b0);
    edge1();
    chk("add_lsu_dest", {27'd0, LSU_reg_dest_op}, 32'd5);
    chk("add_ex_bubble", {27'd0, EX_reg_dest_op}, 32'd0);
    edge1();
    chk("add_wb_dest", {27'd0, WB_reg_dest_op}, 32'd5);
    chk("add_wb_wen", {31'd0, WB_write_reg_en_op}, 32'd1);
    edge1();
    chk("add_wb_drain", {26'd0, WB_reg_dest_op, WB_write_reg_en_op}, 32'd0);

    // STORE with rd field 5 must not advertise a destination.
    drive(1'b1, OP_STORE, 5'd5, 1'b0, 1'b0);
    edge1();
    chk("st_ex_dest", {27'd0, EX_reg_dest_op}, 32'd0);
    chk("st_ex_op", {25'd0, EX_instr_opcode_op}, {25'd0, OP_STORE});
    // ADD x0 right behind it.
    drive(1'b1, OP_ADD, 5'd0, 1'b0, 1'b0);
    edge1();
    drive(1'b0, 7'd0, 5'd0, 1'b0, 1'b0);
    edge1();
    chk("st_wb", {26'd0, WB_reg_dest_op, WB_write_reg_en_op}, 32'd0);
    edge1();
    chk("x0_wb", {26'd0, WB_reg_dest_op, WB_write_reg_en_op}, 32'd0);

    // Two-cycle stall on ADD x9.
    drive(1'b1, OP_ADD, 5'd9, 1'b1, 1'b0);
    chk("stl_hold1", {31'd0, IF_ID_hold_op}, 32'd1);
    edge1();
    chk("stl_ex1", {25'd0, EX_instr_opcode_op}, 32'd0);
    chk("stl_hold2", {31'd0, IF_ID_hold_op}, 32'd1);
    edge1();
    chk("stl_ex2", {27'd0, EX_reg_dest_op}, 32'd0);
    chk("stl_count", {16'd0, stall_count_op}, 32'd2);
    drive(1'b1, OP_ADD, 5'd9, 1'b0, 1'b0);
    chk("stl_release", {31'd0, IF_ID_hold_op}, 32'd0);
    edge1();
    chk("stl_ex3", {27'd0, EX_reg_dest_op}, 32'd9);

    // Stall together with flush: flush wins.
    drive(1'b1, OP_ADD, 5'd12, 1'b1, 1'b1);
    chk("sf_hold", {31'd0, IF_ID_hold_op}, 32'd0);
    edge1();
    chk("sf_ex", {27'd0, EX_reg_dest_op}, 32'd0);
    chk("sf_count", {16'd0, stall_count_op}, 32'd2);

    // 14-cycle stall then release: no timeout.
    drive(1'b1, OP_ADD, 5'd1, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) edge1();
    drive(1'b0, 7'd0, 5'd0, 1'b0, 1'b0);
    edge1();
    chk("wd14_flag", {31'd0, stall_timeout_op}, 32'd0);
    chk("wd14_count", {16'd0, stall_count_op}, 32'd16);

    // 15-cycle stall: flag rises on edge 15 and sticks.
    drive(1'b1, OP_ADD, 5'd1, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) edge1();
    chk("wd15_pre", {31'd0, stall_timeout_op}, 32'd0);
    edge1();
    chk("wd15_flag", {31'd0, stall_timeout_op}, 32'd1);
    drive(1'b0, 7'd0, 5'd0, 1'b0, 1'b0);
    edge1();
    edge1();
    chk("wd15_sticky", {31'd0, stall_timeout_op}, 32'd1);
    chk("wd15_count", {16'd0, stall_count_op}, 32'd31);

    // Reset mid-flight with LOAD x7 in LSU.
    drive(1'b1, OP_LOAD, 5'd7, 1'b0, 1'b0);
    edge1();
    drive(1'b0, 7'd0, 5'd0, 1'b0, 1'b0);
    edge1();
    chk("ld_lsu", {27'd0, LSU_reg_dest_op}, 32'd7);
    reset = 1'b0;
    #1;
    chk("mr_lsu", {27'd0, LSU_reg_dest_op}, 32'd0);
    chk("mr_ex", {25'd0, EX_instr_opcode_op}, 32'd0);
    chk("mr_count", {16'd0, stall_count_op}, 32'd0);
    chk("mr_flag", {31'd0, stall_timeout_op}, 32'd0);
    #1;
    reset = 1'b1;
    drive(1'b1, OP_ADD, 5'd3, 1'b0, 1'b0);
    edge1();
    chk("mr_first_ex", {27'd0, EX_reg_dest_op}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
